// File: rtl/vmm_psum_accum_pkg.sv
// Shared defaults and FSM state encoding for the VMM partial-sum accumulator.
package vmm_psum_accum_pkg;

  localparam int TOUT_DEF    = 8;
  localparam int PSUM_DW_DEF = 20;
  localparam int ACC_DW_DEF  = 32;
  localparam int DEPTH_DEF   = 16;
  localparam int CNT_DW_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vmm_psum_accum_lane.sv
// One accumulator lane: sign-extends a VMM partial sum and either overwrites or adds.
// With PSUM_SATURATE_EN defined the add clamps to the ACC_DW signed range and flags it.
module vmm_psum_accum_lane #(
  parameter int PSUM_DW = 20,
  parameter int ACC_DW  = 32
) (
  input  logic [PSUM_DW-1:0] psum,
  input  logic [ACC_DW-1:0]  acc,
  input  logic               first,
  output logic [ACC_DW-1:0]  sum
`ifdef PSUM_SATURATE_EN
  ,
  output logic               sat
`endif
);

  logic signed [PSUM_DW-1:0] psum_s;
  logic signed [ACC_DW-1:0]  psum_ext;
  logic signed [ACC_DW-1:0]  acc_s;

  assign psum_s   = psum;
  assign acc_s    = acc;
  assign psum_ext = ACC_DW'(psum_s);

`ifdef PSUM_SATURATE_EN
  logic signed [ACC_DW:0] wide;

  // One guard bit is enough: a disagreement between the top two bits means overflow.
  function automatic logic [ACC_DW-1:0] clamp(input logic signed [ACC_DW:0] v);
    if (v[ACC_DW] == v[ACC_DW-1]) return v[ACC_DW-1:0];
    return v[ACC_DW] ? {1'b1, {(ACC_DW-1){1'b0}}} : {1'b0, {(ACC_DW-1){1'b1}}};
  endfunction

  assign wide = (ACC_DW+1)'(acc_s) + (ACC_DW+1)'(psum_ext);
  assign sat  = !first && (wide[ACC_DW] != wide[ACC_DW-1]);
  assign sum  = first ? psum_ext : clamp(wide);
`else
  assign sum  = first ? psum_ext : acc_s + psum_ext;
`endif

endmodule

// File: rtl/vmm_psum_accum.sv
// Accumulates VMM partial sums across input-channel tiles per output pixel, then drains
// the finished sums one pixel per handshake. Optional clamp + sat_flag via PSUM_SATURATE_EN.
module vmm_psum_accum
  import vmm_psum_accum_pkg::*;
#(
  parameter int TOUT    = TOUT_DEF,
  parameter int PSUM_DW = PSUM_DW_DEF,
  parameter int ACC_DW  = ACC_DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_DW  = CNT_DW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_pix_num,
  input  logic [CNT_DW-1:0]          cfg_tile_num,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [PSUM_DW*TOUT-1:0]    i_dat,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [ACC_DW*TOUT-1:0]     o_dat,
  output logic                       o_done,
  output logic                       busy
`ifdef PSUM_SATURATE_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int PW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  state_e                   state_q, state_d;
  logic [PW-1:0]            pix_cnt_q, pix_cnt_d;
  logic [CNT_DW-1:0]        tile_cnt_q, tile_cnt_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            cfg_pix_q, cfg_pix_d;
  logic [CNT_DW-1:0]        cfg_tile_q, cfg_tile_d;
  logic                     o_vld_q, o_vld_d;
  logic                     o_done_q, o_done_d;
  logic [ACC_DW*TOUT-1:0]   o_dat_q, o_dat_d;

  logic [ACC_DW*TOUT-1:0]   mem [DEPTH];
  logic [ACC_DW*TOUT-1:0]   acc_sum;
  logic [AW-1:0]            wr_idx;
  logic [AW-1:0]            rd_idx;
  logic                     beat;
  logic                     start_ok;
  logic                     tile_first;

  assign wr_idx     = pix_cnt_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign beat       = i_vld && (state_q == ST_ACCUM);
  assign tile_first = (tile_cnt_q == '0);
  // The o_done cycle is already IDLE, but a start there is deliberately held off one cycle.
  assign start_ok   = start && (state_q == ST_IDLE) && !o_done_q;

`ifdef PSUM_SATURATE_EN
  logic [TOUT-1:0] lane_sat;
`endif

  for (genvar k = 0; k < TOUT; k++) begin : g_lane
    vmm_psum_accum_lane #(
      .PSUM_DW (PSUM_DW),
      .ACC_DW  (ACC_DW)
    ) u_lane (
      .psum  (i_dat[k*PSUM_DW +: PSUM_DW]),
      .acc   (mem[wr_idx][k*ACC_DW +: ACC_DW]),
      .first (tile_first),
      .sum   (acc_sum[k*ACC_DW +: ACC_DW])
`ifdef PSUM_SATURATE_EN
      ,
      .sat   (lane_sat[k])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (beat) mem[wr_idx] <= acc_sum;
  end

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    tile_cnt_d = tile_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    cfg_pix_d  = cfg_pix_q;
    cfg_tile_d = cfg_tile_q;
    o_vld_d    = o_vld_q;
    o_dat_d    = o_dat_q;
    o_done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cfg_pix_d  = cfg_pix_num;
          cfg_tile_d = cfg_tile_num;
          pix_cnt_d  = '0;
          tile_cnt_d = '0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (i_vld) begin
          if (pix_cnt_q == cfg_pix_q - PW'(1)) begin
            pix_cnt_d  = '0;
            tile_cnt_d = tile_cnt_q + CNT_DW'(1);
            if (tile_cnt_q == cfg_tile_q - CNT_DW'(1)) begin
              rd_ptr_d = '0;
              state_d  = ST_DRAIN;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // rd_ptr is the next pixel to load into the output register.
        if (!o_vld_q || o_rdy) begin
          if (rd_ptr_q == cfg_pix_q) begin
            o_vld_d  = 1'b0;
            o_done_d = o_vld_q;
            state_d  = ST_IDLE;
          end else begin
            o_vld_d  = 1'b1;
            o_dat_d  = mem[rd_idx];
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      tile_cnt_q <= '0;
      rd_ptr_q   <= '0;
      cfg_pix_q  <= '0;
      cfg_tile_q <= '0;
      o_vld_q    <= 1'b0;
      o_done_q   <= 1'b0;
      o_dat_q    <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      cfg_pix_q  <= cfg_pix_d;
      cfg_tile_q <= cfg_tile_d;
      o_vld_q    <= o_vld_d;
      o_done_q   <= o_done_d;
      o_dat_q    <= o_dat_d;
    end
  end

`ifdef PSUM_SATURATE_EN
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    sat_flag_d = sat_flag_q;
    if (start_ok)                sat_flag_d = 1'b0;
    else if (beat && |lane_sat)  sat_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_flag_q <= 1'b0;
    else     sat_flag_q <= sat_flag_d;
  end

  assign sat_flag = sat_flag_q;
`endif

  assign i_rdy  = (state_q == ST_ACCUM);
  assign busy   = (state_q != ST_IDLE);
  assign o_vld  = o_vld_q;
  assign o_dat  = o_dat_q;
  assign o_done = o_done_q;

endmodule

// File: tb/tb_vmm_psum_accum.sv
// Randomized scoreboard bench for vmm_psum_accum: a main instance plus a narrow
// ACC_DW=PSUM_DW instance for overflow behaviour (wrap, or clamp with PSUM_SATURATE_EN).
module tb_vmm_psum_accum;

  localparam int TOUT    = 8;
  localparam int PSUM_DW = 20;
  localparam int ACC_DW  = 32;
  localparam int DEPTH   = 16;
  localparam int CNT_DW  = 8;
  localparam int PW      = $clog2(DEPTH+1);
  localparam int S_TOUT  = 2;
  localparam int S_ACC   = PSUM_DW;
  localparam int S_DEPTH = 4;
  localparam int S_CNT   = 4;
  localparam int S_PW    = $clog2(S_DEPTH+1);

  typedef struct {
    logic [ACC_DW*TOUT-1:0] dat;
    bit                     last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    start, i_vld, i_rdy, o_vld, o_rdy, o_done, busy;
  logic [PW-1:0]           cfg_pix_num;
  logic [CNT_DW-1:0]       cfg_tile_num;
  logic [PSUM_DW*TOUT-1:0] i_dat;
  logic [ACC_DW*TOUT-1:0]  o_dat;

  logic                      s_start, s_i_vld, s_i_rdy, s_o_vld, s_o_rdy, s_o_done, s_busy;
  logic [S_PW-1:0]           s_cfg_pix;
  logic [S_CNT-1:0]          s_cfg_tile;
  logic [PSUM_DW*S_TOUT-1:0] s_i_dat;
  logic [S_ACC*S_TOUT-1:0]   s_o_dat;

`ifdef PSUM_SATURATE_EN
  logic sat_flag, s_sat_flag;
`endif

  vmm_psum_accum #(.TOUT(TOUT), .PSUM_DW(PSUM_DW), .ACC_DW(ACC_DW), .DEPTH(DEPTH), .CNT_DW(CNT_DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pix_num(cfg_pix_num), .cfg_tile_num(cfg_tile_num),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat), .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat),
    .o_done(o_done), .busy(busy)
`ifdef PSUM_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  vmm_psum_accum #(.TOUT(S_TOUT), .PSUM_DW(PSUM_DW), .ACC_DW(S_ACC), .DEPTH(S_DEPTH), .CNT_DW(S_CNT)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .cfg_pix_num(s_cfg_pix), .cfg_tile_num(s_cfg_tile),
    .i_vld(s_i_vld), .i_rdy(s_i_rdy), .i_dat(s_i_dat), .o_vld(s_o_vld), .o_rdy(s_o_rdy), .o_dat(s_o_dat),
    .o_done(s_o_done), .busy(s_busy)
`ifdef PSUM_SATURATE_EN
    , .sat_flag(s_sat_flag)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   rdy_mode = 0;
  logic [3:0] rdy_pat = 4'b1001;
  int   rdy_ph = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference arithmetic: the true integer sum folded back into a w-bit signed range.
  function automatic bit ovf(input longint v, input int w);
    longint mx = (longint'(1) <<< (w-1)) - 1;
    longint mn = -(longint'(1) <<< (w-1));
    return (v > mx) || (v < mn);
  endfunction

  function automatic longint fold(input longint v, input int w);
    longint mx = (longint'(1) <<< (w-1)) - 1;
    longint mn = -(longint'(1) <<< (w-1));
    longint m  = longint'(1) <<< w;
    longint r;
`ifdef PSUM_SATURATE_EN
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
`else
    r = v & (m - 1);
    if (r > mx) r = r - m;
    return r;
`endif
  endfunction

  always @(posedge clk)
    if (!rst && start && !busy && !o_done)
      assert (cfg_pix_num != 0 && cfg_tile_num != 0 && cfg_pix_num <= DEPTH)
        else $error("FAIL illegal_cfg pix=%0d tiles=%0d", cfg_pix_num, cfg_tile_num);

  initial begin
    o_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: o_rdy = 1'b1;
        1: begin o_rdy = rdy_pat[rdy_ph]; rdy_ph = (rdy_ph + 1) % 4; end
        default: o_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer and checks drain protocol.
  bit                     expect_done = 0;
  bit                     prev_stall  = 0;
  logic [ACC_DW*TOUT-1:0] prev_dat;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expect_done = 0;
      prev_stall  = 0;
    end else begin
      if (expect_done) begin
        chk("done_pulse", {o_done, o_vld}, 2'b10);
        expect_done = 0;
      end else if (o_done) begin
        chk("spurious_done", o_done, 1'b0);
      end
      if (prev_stall) chk("stall_stable", {o_vld, o_dat}, {1'b1, prev_dat});
      if (o_vld) chk("i_rdy_in_drain", i_rdy, 1'b0);
      if (o_vld && o_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", o_vld, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", o_dat, e.dat);
          if (e.last) expect_done = 1;
        end
      end
      prev_stall = o_vld && !o_rdy;
      prev_dat   = o_dat;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || o_done) && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("wait_idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic send_beat(input logic [PSUM_DW*TOUT-1:0] b);
    bit acc = 0;
    int n = 0;
    i_vld = 1'b1;
    i_dat = b;
    while (!acc && n < 50) begin
      @(negedge clk); acc = i_rdy;
      @(posedge clk); #1; n++;
    end
    if (!acc) chk("beat_accept_timeout", 1'b1, 1'b0);
    i_vld = 1'b0;
  endtask

  // mode 0: p*10+t+k pattern, 1: signed -5/+3 on lane 0, 2: random full-range data.
  task automatic run_job(input int pix, input int tiles, input int mode, input bit inj);
    logic [PSUM_DW*TOUT-1:0] beats[$];
    logic [PSUM_DW*TOUT-1:0] b;
    logic [PSUM_DW-1:0]      lv;
    logic [63:0]             rb;
    longint                  acc [DEPTH][TOUT];
    longint                  x;
    bit                      job_sat = 0;
    exp_t                    e;
    int                      n;
    for (int t = 0; t < tiles; t++)
      for (int p = 0; p < pix; p++) begin
        b = '0;
        for (int k = 0; k < TOUT; k++) begin
          if (mode == 0)      x = p*10 + t + k;
          else if (mode == 1) x = (k == 0) ? ((t == 0) ? -5 : 3) : 0;
          else                x = longint'(signed'(PSUM_DW'($urandom)));
          lv = PSUM_DW'(x);
          x  = longint'(signed'(lv));
          b[k*PSUM_DW +: PSUM_DW] = lv;
          if (t == 0) acc[p][k] = x;
          else begin
            if (ovf(acc[p][k] + x, ACC_DW)) job_sat = 1;
            acc[p][k] = fold(acc[p][k] + x, ACC_DW);
          end
        end
        beats.push_back(b);
      end
    for (int p = 0; p < pix; p++) begin
      for (int k = 0; k < TOUT; k++) begin
        rb = acc[p][k];
        e.dat[k*ACC_DW +: ACC_DW] = rb[ACC_DW-1:0];
      end
      e.last = (p == pix - 1);
      exp_q.push_back(e);
    end
    wait_idle();
    if (inj) begin
      i_vld = 1'b1; i_dat = {TOUT{20'h5A5A5}};
      @(negedge clk); chk("idle_i_rdy", i_rdy, 1'b0);
      @(posedge clk); #1; i_vld = 1'b0;
    end
    cfg_pix_num = PW'(pix); cfg_tile_num = CNT_DW'(tiles); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    foreach (beats[i]) begin
      if (mode == 2 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_beat(beats[i]);
    end
    if (inj) begin
      cfg_pix_num = PW'(2); cfg_tile_num = CNT_DW'(1); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    n = 0;
    while (!o_done && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("done_timeout", 1'b1, 1'b0);
    if (inj) begin
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); chk("start_in_done_ignored", busy, 1'b0);
    end
`ifdef PSUM_SATURATE_EN
    chk("sat_flag_main", sat_flag, job_sat);
`else
    if (job_sat) chk("model_ovf_unexpected", 1'b1, 1'b0);
`endif
  endtask

  task automatic run_small(input longint a0, input longint a1, input longint b0, input longint b1);
    logic [S_ACC*S_TOUT-1:0] ew;
    logic [63:0]             r0, r1;
    bit                      es, acc;
    int                      n;
    es = ovf(a0 + a1, S_ACC) || ovf(b0 + b1, S_ACC);
    r0 = fold(a0 + a1, S_ACC);
    r1 = fold(b0 + b1, S_ACC);
    ew = {r1[S_ACC-1:0], r0[S_ACC-1:0]};
    s_cfg_pix = S_PW'(1); s_cfg_tile = S_CNT'(2); s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_i_vld = 1'b1;
      s_i_dat = (i == 0) ? {PSUM_DW'(b0), PSUM_DW'(a0)} : {PSUM_DW'(b1), PSUM_DW'(a1)};
      acc = 0; n = 0;
      while (!acc && n < 20) begin
        @(negedge clk); acc = s_i_rdy;
        @(posedge clk); #1; n++;
      end
      if (!acc) chk("small_accept_timeout", 1'b1, 1'b0);
    end
    s_i_vld = 1'b0;
    n = 0;
    while (!s_o_vld && n < 20) begin @(posedge clk); #1; n++; end
    chk("small_o_dat", {s_o_vld, s_o_dat}, {1'b1, ew});
`ifdef PSUM_SATURATE_EN
    chk("small_sat_flag", s_sat_flag, es);
`else
    if (es) chk("small_wrap_vld", s_o_vld, 1'b1);
`endif
    n = 0;
    while ((s_busy || s_o_done) && n < 20) begin @(posedge clk); #1; n++; end
    chk("small_idle", s_busy, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; i_vld = 1'b0; i_dat = '0; cfg_pix_num = '0; cfg_tile_num = '0;
    s_start = 1'b0; s_i_vld = 1'b0; s_i_dat = '0; s_cfg_pix = '0; s_cfg_tile = '0; s_o_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {i_rdy, o_vld, o_done, busy}, 4'b0000);
    chk("reset_o_dat", o_dat, '0);
`ifdef PSUM_SATURATE_EN
    chk("reset_sat_flag", sat_flag, 1'b0);
`endif
    @(posedge clk); #1;

    rdy_mode = 0; run_job(4, 3, 0, 0);
    run_job(1, 2, 1, 0);
    rdy_mode = 1; run_job(6, 2, 2, 0);
    rdy_mode = 0; run_job(1, 1, 2, 0);
    run_job(DEPTH, 1, 2, 0);
    for (int j = 0; j < 4; j++) begin
      rdy_mode = $urandom_range(0, 2);
      run_job($urandom_range(1, DEPTH), $urandom_range(1, 4), 2, 0);
    end

    // Abort in tile 1 of 3, then a single-tile job must see only its own data.
    wait_idle();
    cfg_pix_num = PW'(4); cfg_tile_num = CNT_DW'(3); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 6; i++) send_beat({TOUT{20'h00777}});
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {busy, i_rdy, o_vld, o_done}, 4'b0000);
    @(posedge clk); #1;
    rdy_mode = 2; run_job(4, 1, 2, 0);

    rdy_mode = 1; run_job(5, 2, 2, 1);

    run_small((longint'(1) <<< (PSUM_DW-1)) - 1, (longint'(1) <<< (PSUM_DW-1)) - 1,
              -(longint'(1) <<< (PSUM_DW-1)), -(longint'(1) <<< (PSUM_DW-1)));
    run_small(100, -30, 5, 7);

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
